// File: rtl/floo_pkg.sv
// Shared flit/header types and the arbiter state encoding used by the output-port stage.
package floo_pkg;

    typedef struct packed {
        logic last;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [15:0] payload;
    } flit_t;

    typedef enum logic {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

endpackage

// File: rtl/floo_rr_prio_select.sv
// Cyclic priority encoder: picks the first set request at or after ptr, wrapping around.
module floo_rr_prio_select #(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic [NumInputs-1:0] req,
    input  logic [IdxWidth-1:0]  ptr,
    output logic [IdxWidth-1:0]  idx,
    output logic                 any
);

    logic [IdxWidth-1:0] cand;

    // Walk offsets from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        idx  = ptr;
        any  = |req;
        cand = '0;
        for (int unsigned k = 0; k < NumInputs; k++) begin
            cand = IdxWidth'((32'(ptr) + (NumInputs - 1 - k)) % NumInputs);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/floo_wormhole_output_arbiter.sv
// Output-port stage: round-robin arbitration with a wormhole lock held until the last flit.
module floo_wormhole_output_arbiter
    import floo_pkg::*;
#(
    parameter int unsigned NumInputs = 4,
    parameter type         flit_t    = floo_pkg::flit_t,
    parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInputs-1:0] valid_i,
    output logic [NumInputs-1:0] ready_o,
    input  flit_t                data_i [NumInputs],
    output logic                 valid_o,
    input  logic                 ready_i,
    output flit_t                data_o,
    output arb_state_e           arb_state
);

    arb_state_e          state_q;
    logic [IdxWidth-1:0] rr_ptr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic [IdxWidth-1:0] sel_idx;
    logic [IdxWidth-1:0] grant;
    logic [IdxWidth-1:0] next_ptr;
    logic                sel_any;
    logic                hs;
    logic                hs_last;

    floo_rr_prio_select #(
        .NumInputs (NumInputs),
        .IdxWidth  (IdxWidth)
    ) u_prio_select (
        .req (valid_i),
        .ptr (rr_ptr_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    assign grant     = (state_q == ArbLocked) ? lock_idx_q : sel_idx;
    assign valid_o   = (state_q == ArbLocked) ? valid_i[lock_idx_q] : sel_any;
    assign data_o    = data_i[grant];
    assign hs        = valid_o & ready_i;
    assign hs_last   = hs & data_o.hdr.last;
    assign next_ptr  = (grant == IdxWidth'(NumInputs - 1)) ? '0 : grant + IdxWidth'(1);
    assign arb_state = state_q;

    // Only the granted input sees ready, and only while it actually offers a flit.
    always_comb begin
        ready_o        = '0;
        ready_o[grant] = hs;
    end

    // A stalled offer also locks, which keeps grant and data_o frozen until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ArbIdle;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            if (state_q == ArbIdle) begin
                if (valid_o && !(ready_i && data_o.hdr.last)) begin
                    state_q    <= ArbLocked;
                    lock_idx_q <= grant;
                end
            end else if (hs_last) begin
                state_q <= ArbIdle;
            end
            if (hs_last) begin
                rr_ptr_q <= next_ptr;
            end
        end
    end

    offer_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> valid_o)
        else $warning("granted input withdrew valid before its flit was accepted");

endmodule

// File: tb/tb_floo_wormhole_output_arbiter.sv
// Directed scenarios plus randomized packet traffic, checked every cycle against a packet-level model.
module tb_floo_wormhole_output_arbiter;
    import floo_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [N-1:0] valid;
    logic [N-1:0] ready_o;
    flit_t        data [N];
    logic         valid_o;
    logic         ready;
    flit_t        data_o;
    arb_state_e   arb_state;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_locked;
    int m_owner;
    int m_ptr;
    int open_pkt;

    always #5 clk = ~clk;

    floo_wormhole_output_arbiter #(.NumInputs(N)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid),
        .ready_o   (ready_o),
        .data_i    (data),
        .valid_o   (valid_o),
        .ready_i   (ready),
        .data_o    (data_o),
        .arb_state (arb_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner of the port: the locked packet's input, else first requester from the pointer.
    function automatic int exp_grant();
        if (m_locked) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return m_ptr;
    endfunction

    // Model: a packet's last flit accepted frees the port and moves priority past its input;
    // any other offer (accepted or stalled) keeps the port owned by that input.
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_locked <= 1'b0;
            m_owner  <= 0;
            m_ptr    <= 0;
        end else if (valid[exp_grant()]) begin
            if (ready && data[exp_grant()].hdr.last) begin
                m_locked <= 1'b0;
                m_ptr    <= (exp_grant() + 1) % N;
            end else begin
                m_locked <= 1'b1;
                m_owner  <= exp_grant();
            end
        end
    end

    always @(negedge clk) begin
        int g;
        int a;
        g = exp_grant();
        chk("valid_o", 32'(valid_o), 32'(valid[g]));
        chk("ready_o", 32'(ready_o), (ready && valid[g]) ? (32'd1 << g) : 32'd0);
        chk("data_o", 32'(data_o), 32'(data[g]));
        chk("state", 32'(arb_state), m_locked ? 32'(ArbLocked) : 32'(ArbIdle));
        if (!rst_ni) begin
            open_pkt <= -1;
        end else if (valid_o && ready) begin
            a = -1;
            for (int k = 0; k < N; k++) if (ready_o[k]) a = k;
            if (open_pkt >= 0) chk("no_interleave", 32'(a), 32'(open_pkt));
            open_pkt <= data_o.hdr.last ? -1 : a;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int i, input logic last);
        data[i].hdr.last = last;
        data[i].payload  = 16'($urandom);
    endtask

    // Literal expectation: input g is the one being accepted this cycle.
    task automatic expect_grant(input string name, input int g);
        @(negedge clk);
        chk({name, "_valid"}, 32'(valid_o), 32'd1);
        chk({name, "_ready"}, 32'(ready_o), 32'd1 << g);
        chk({name, "_data"}, 32'(data_o), 32'(data[g]));
        chk({name, "_model"}, 32'(exp_grant()), 32'(g));
    endtask

    int rem [N];
    logic [N-1:0] acc;

    initial begin
        rst_ni = 1'b0;
        valid  = '0;
        ready  = 1'b1;
        for (int i = 0; i < N; i++) set_flit(i, 1'b1);

        // Reset with nothing requested.
        @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'(data[0]));
        chk("rst_state", 32'(arb_state), 32'(ArbIdle));
        step();
        rst_ni = 1'b1;
        step();

        // Two single-flit requesters alternate: 1,3,1,3.
        valid = 4'b1010;
        expect_grant("alt0", 1); step(); set_flit(1, 1'b1); set_flit(3, 1'b1);
        expect_grant("alt1", 3); step(); set_flit(1, 1'b1); set_flit(3, 1'b1);
        expect_grant("alt2", 1); step(); set_flit(1, 1'b1); set_flit(3, 1'b1);
        expect_grant("alt3", 3); step();
        valid = '0;

        // Three-flit packet on input 0 holds the port against input 2.
        valid = 4'b0101;
        set_flit(0, 1'b0); set_flit(2, 1'b1);
        expect_grant("pkt_f1", 0); step(); set_flit(0, 1'b0);
        expect_grant("pkt_f2", 0); step(); set_flit(0, 1'b1);
        expect_grant("pkt_f3", 0); step(); valid[0] = 1'b0;
        expect_grant("pkt_next", 2); step();
        valid = '0;

        // Stalled offer from input 2 is not preempted by input 1.
        valid = 4'b0100;
        ready = 1'b0;
        set_flit(2, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                valid[1] = 1'b1;
                set_flit(1, 1'b1);
            end
            @(negedge clk);
            chk("stall_data", 32'(data_o), 32'(data[2]));
            chk("stall_ready", 32'(ready_o), 32'd0);
            step();
        end
        ready = 1'b1;
        expect_grant("stall_rel", 2); step(); valid[2] = 1'b0;
        expect_grant("stall_next", 1); step();
        valid = '0;

        // Locked input 3 pauses mid-packet; input 0 must wait.
        valid = 4'b1001;
        set_flit(3, 1'b0); set_flit(0, 1'b1);
        expect_grant("gap_head", 3); step(); valid[3] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("gap_valid_o", 32'(valid_o), 32'd0);
            chk("gap_ready_o", 32'(ready_o), 32'd0);
            chk("gap_state", 32'(arb_state), 32'(ArbLocked));
            step();
        end
        valid[3] = 1'b1;
        set_flit(3, 1'b1);
        expect_grant("gap_tail", 3); step(); valid[3] = 1'b0;
        expect_grant("gap_next", 0); step();
        valid = '0;

        // Reset while locked on input 2 with pointer at 3.
        valid = 4'b0100;
        set_flit(2, 1'b1);
        expect_grant("rl_single", 2); step(); set_flit(2, 1'b0);
        expect_grant("rl_head", 2); step(); valid = '0;
        @(negedge clk);
        chk("rl_locked", 32'(arb_state), 32'(ArbLocked));
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rl_async_idle", 32'(arb_state), 32'(ArbIdle));
        step();
        step();
        rst_ni = 1'b1;
        valid = 4'b1111;
        for (int i = 0; i < N; i++) set_flit(i, 1'b1);
        expect_grant("rl_after", 0); step();
        valid = '0;

        // Random packet traffic; offers are held until accepted, bubbles only after a flit.
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = ready_o & valid;
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    rem[i]--;
                    if (rem[i] == 0 || $urandom_range(0, 3) == 0) begin
                        valid[i] = 1'b0;
                        set_flit(i, 1'($urandom));
                    end else begin
                        set_flit(i, rem[i] == 1);
                    end
                end else if (!valid[i]) begin
                    if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                        rem[i] = $urandom_range(1, 4);
                    end
                    if (rem[i] > 0 && $urandom_range(0, 1) == 1) begin
                        valid[i] = 1'b1;
                        set_flit(i, rem[i] == 1);
                    end
                end
            end
            ready = ($urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
